// File: rtl/nano_dmem_arb_pkg.sv
// Shared types and default widths for the NanoController DMEM arbiter.
package nano_dmem_arb_pkg;

    localparam int unsigned NANO_D_W_DEF      = 8;
    localparam int unsigned NANO_D_ADR_W_DEF  = 6;
    localparam int unsigned HOST_MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CORE = 2'd1,
        RD_HOST = 2'd2
    } rd_owner_t;

    // Counter width able to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/nano_starve_cnt.sv
// Saturating starvation counter: counts denied request cycles up to MAX_C.
module nano_starve_cnt
    import nano_dmem_arb_pkg::*;
#(
    parameter  int unsigned MAX_C = HOST_MAX_WAIT_DEF,
    localparam int unsigned CNT_W = cnt_width(MAX_C)
) (
    input  logic i_nano_clk,
    input  logic i_nano_rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_max_c
);

    logic [CNT_W-1:0] cnt;

    assign at_max_c = (cnt == CNT_W'(MAX_C));

    // Clear has priority over increment; holds once saturated.
    always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
        if (!i_nano_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nano_dmem_arbiter.sv
// Shares the single-port DMEM between the NanoController core (default priority)
// and a host/debug port, and steers synchronous read data back to its requester.
module nano_dmem_arbiter
    import nano_dmem_arb_pkg::*;
#(
    parameter int unsigned NANO_D_W_C      = NANO_D_W_DEF,
    parameter int unsigned NANO_D_ADR_W_C  = NANO_D_ADR_W_DEF,
    parameter int unsigned HOST_MAX_WAIT_C = HOST_MAX_WAIT_DEF
) (
    input  logic                      i_nano_clk,
    input  logic                      i_nano_rst_n,
    input  logic                      i_core_dmem_oe,
    input  logic                      i_core_dmem_we,
    input  logic [NANO_D_ADR_W_C-1:0] i_core_dmem_addr,
    input  logic [NANO_D_W_C-1:0]     i_core_dmem_in,
    output logic [NANO_D_W_C-1:0]     o_core_dmem_out,
    output logic                      o_core_stall,
    input  logic                      i_host_req,
    input  logic                      i_host_we,
    input  logic [NANO_D_ADR_W_C-1:0] i_host_addr,
    input  logic [NANO_D_W_C-1:0]     i_host_wdata,
    output logic                      o_host_gnt,
    output logic [NANO_D_W_C-1:0]     o_host_rdata,
    output logic                      o_host_rvalid,
    output logic                      o_dmem_oe,
    output logic                      o_dmem_we,
    output logic [NANO_D_ADR_W_C-1:0] o_dmem_addr,
    output logic [NANO_D_W_C-1:0]     o_dmem_in,
    input  logic [NANO_D_W_C-1:0]     i_dmem_out
);

    logic                  core_act;
    logic                  host_win;
    logic                  wait_at_max;
    rd_owner_t             rd_owner;
    rd_owner_t             rd_owner_nxt;
    logic [NANO_D_W_C-1:0] core_data_q;
    logic [NANO_D_W_C-1:0] host_rdata_q;

    assign core_act = i_core_dmem_oe | i_core_dmem_we;
    assign host_win = i_host_req & (~core_act | wait_at_max);

    nano_starve_cnt #(
        .MAX_C (HOST_MAX_WAIT_C)
    ) u_wait_cnt (
        .i_nano_clk   (i_nano_clk),
        .i_nano_rst_n (i_nano_rst_n),
        .clr          (host_win | ~i_host_req),
        .inc          (i_host_req & ~host_win),
        .at_max_c     (wait_at_max)
    );

    // DMEM port mux; everything is held quiet while reset is asserted.
    always_comb begin
        o_dmem_oe    = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_in    = '0;
        o_host_gnt   = 1'b0;
        o_core_stall = 1'b0;
        rd_owner_nxt = RD_NONE;
        if (i_nano_rst_n) begin
            if (host_win) begin
                o_dmem_oe    = ~i_host_we;
                o_dmem_we    = i_host_we;
                o_dmem_addr  = i_host_addr;
                o_dmem_in    = i_host_wdata;
                o_host_gnt   = 1'b1;
                o_core_stall = core_act;
                rd_owner_nxt = i_host_we ? RD_NONE : RD_HOST;
            end else if (core_act) begin
                o_dmem_oe    = i_core_dmem_oe;
                o_dmem_we    = i_core_dmem_we;
                o_dmem_addr  = i_core_dmem_addr;
                o_dmem_in    = i_core_dmem_in;
                rd_owner_nxt = i_core_dmem_oe ? RD_CORE : RD_NONE;
            end
        end
    end

    always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
        if (!i_nano_rst_n) begin
            rd_owner     <= RD_NONE;
            core_data_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            rd_owner <= rd_owner_nxt;
            if (rd_owner == RD_CORE) begin
                core_data_q <= i_dmem_out;
            end
            if (rd_owner == RD_HOST) begin
                host_rdata_q <= i_dmem_out;
            end
        end
    end

    // Return data passes straight through in its cycle, then is held.
    always_comb begin
        o_host_rvalid   = (rd_owner == RD_HOST);
        o_host_rdata    = o_host_rvalid ? i_dmem_out : host_rdata_q;
        o_core_dmem_out = (rd_owner == RD_CORE) ? i_dmem_out : core_data_q;
    end

endmodule
